counter_arbiter: RTL and testbench
==================================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001: The block SHALL use one clock, clk; all state SHALL update on its rising edge.
REQ-002: clk  input  1  system clock.
REQ-003: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004: reqN  input  1  (N=0,1) request; held high by the requester until gntN.
REQ-005: opN  input  2  request op; bit1=load-first, bit0=direction (1 up, 0 down).
REQ-006: ldvalN  input  16  load value, used when opN[1]=1.
REQ-007: lenN  input  8  number of count-enabled cycles; 0 means no counting.
REQ-008: gntN  output  1  one-cycle grant pulse; request fields are latched on the same edge that raises it.
REQ-009: doneN  output  1  one-cycle completion pulse to the granted requester.
REQ-010: cnt_data_in  output  16  load value driven to the shared counter.
REQ-011: cnt_ld_cnt  output  1  counter load, active low.
REQ-012: cnt_updn_cnt  output  1  counter direction, 1=up.
REQ-013: cnt_count_enb  output  1  counter enable, active high.
REQ-014: cnt_data_out  input  16  current counter value.
REQ-015: result  output  16  counter value captured at completion; holds until the next completion.
REQ-016: busy  output  1  high in every state except IDLE.

Function
REQ-017: FSM states SHALL be IDLE, LOAD, RUN, DONE; all outputs SHALL be registered.
REQ-018: IDLE: cnt_ld_cnt=1, cnt_count_enb=0; reqN SHALL be sampled only in IDLE.
REQ-019: On any sampled request, the winner's op, ldval and len SHALL be latched, gnt SHALL pulse for the next cycle only, and the next state SHALL be:
- LOAD if op[1]=1;
- else RUN if len!=0;
- else DONE.
REQ-020: LOAD SHALL last exactly one cycle with cnt_ld_cnt=0 and cnt_data_in=latched ldval, then go to RUN if len!=0, else DONE.
REQ-021: RUN SHALL hold cnt_count_enb=1 and cnt_updn_cnt=latched op[0] for exactly len consecutive cycles, tracked by an 8-bit remaining-count, then go to DONE.
REQ-022: DONE SHALL last one cycle:
- pulse doneN of the granted requester;
- load result from cnt_data_out;
- return to IDLE.
REQ-023: The counter outputs SHALL be inactive in DONE (cnt_ld_cnt=1, cnt_count_enb=0).
REQ-024: Timing for an op with load and len=L, request sampled in cycle 0:
- gnt and LOAD in cycle 1;
- RUN in cycles 2..L+1;
- DONE in cycle L+2;
- IDLE in cycle L+3;
- earliest next gnt in cycle L+4.
REQ-025: Requests asserted while busy SHALL be ignored until IDLE; no request SHALL be lost while it is held.
REQ-026: Counter wrap-around (0xFFFF+1, 0x0000-1) SHALL NOT be detected or altered by this block.
REQ-027: cnt_data_in SHALL hold the last latched ldval when not in LOAD.
REQ-028: This block SHALL NOT drive the counter's reset.

Reset
REQ-029: On rst=1 at a clock edge, from any state, the block SHALL:
- go to IDLE;
- clear gnt0/1, done0/1, busy, cnt_count_enb, cnt_updn_cnt, cnt_data_in and result to 0;
- set cnt_ld_cnt to 1;
- set the round-robin pointer so that req0 wins next.
REQ-030: A reset mid-operation SHALL abort the operation with no doneN pulse.

Configuration
REQ-031: Macro CNT_ARB_FIXED_PRIORITY_EN SHALL select the arbitration policy.
- Defined: req0 always wins simultaneous requests.
- Undefined: round-robin; on simultaneous requests the requester not granted most recently wins, and the pointer updates on every grant.

Verification
REQ-032: rst=1 for 2 cycles then 0 -> busy=0, cnt_ld_cnt=1, cnt_count_enb=0, result=0, all gnt/done=0.
REQ-033: req0, op0=11, ldval0=0x0010, len0=5 -> gnt0 in cycle 1; LOAD 1 cycle; enable for 5 cycles; done0 in cycle 7; result=0x0015.
REQ-034: req1, op1=10, ldval1=0x0000, len1=1 -> down count wraps; done1 pulses; result=0xFFFF.
REQ-035: req0 and req1 high together, twice back-to-back:
- round-robin build: gnt0 then gnt1;
- CNT_ARB_FIXED_PRIORITY_EN build: gnt0 both times.
REQ-036: op0=00, len0=0 -> gnt0, DONE the next cycle; cnt_count_enb and cnt_ld_cnt never active; result=cnt_data_out.
REQ-037: rst=1 in the third RUN cycle of a len=10 op -> IDLE on the next cycle, cnt_count_enb=0, no done0 pulse.

Source files
------------

// File: rtl/counter_arbiter_if.sv
// Request/grant and shared-counter signal bundle for counter_arbiter.
// slave is the arbiter side; master is the requester/counter side.
interface counter_arbiter_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 8;

  logic              req0;
  logic              req1;
  logic [1:0]        op0;
  logic [1:0]        op1;
  logic [DATA_W-1:0] ldval0;
  logic [DATA_W-1:0] ldval1;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W-1:0]  len1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] cnt_data_in;
  logic              cnt_ld_cnt;
  logic              cnt_updn_cnt;
  logic              cnt_count_enb;
  logic [DATA_W-1:0] cnt_data_out;
  logic [DATA_W-1:0] result;
  logic              busy;

  modport slave (
    input  req0, req1, op0, op1, ldval0, ldval1, len0, len1, cnt_data_out,
    output gnt0, gnt1, done0, done1, cnt_data_in, cnt_ld_cnt, cnt_updn_cnt,
           cnt_count_enb, result, busy
  );

  modport master (
    output req0, req1, op0, op1, ldval0, ldval1, len0, len1, cnt_data_out,
    input  gnt0, gnt1, done0, done1, cnt_data_in, cnt_ld_cnt, cnt_updn_cnt,
           cnt_count_enb, result, busy
  );
endinterface

// File: rtl/counter_arbiter.sv
// Two-requester arbiter sequencing load/count operations on a shared counter.
// CNT_ARB_FIXED_PRIORITY_EN selects fixed priority (req0 wins); default is round-robin.
module counter_arbiter (
  input logic              clk,
  input logic              rst,
  counter_arbiter_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic              owner;
  logic              dir_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  remaining;

  logic              any_req;
  logic              win;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_ldval;
  logic [LEN_W-1:0]  sel_len;

`ifndef CNT_ARB_FIXED_PRIORITY_EN
  logic              last_gnt;
`endif

  // Winner selection and the winner's request fields
  always_comb begin
    any_req = bus.req0 | bus.req1;
`ifdef CNT_ARB_FIXED_PRIORITY_EN
    win = ~bus.req0;
`else
    win = (bus.req0 & bus.req1) ? ~last_gnt : bus.req1;
`endif
    sel_op    = win ? bus.op1    : bus.op0;
    sel_ldval = win ? bus.ldval1 : bus.ldval0;
    sel_len   = win ? bus.len1   : bus.len0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      owner             <= 1'b0;
      dir_q             <= 1'b0;
      len_q             <= '0;
      remaining         <= '0;
      bus.gnt0          <= 1'b0;
      bus.gnt1          <= 1'b0;
      bus.done0         <= 1'b0;
      bus.done1         <= 1'b0;
      bus.busy          <= 1'b0;
      bus.cnt_ld_cnt    <= 1'b1;
      bus.cnt_count_enb <= 1'b0;
      bus.cnt_updn_cnt  <= 1'b0;
      bus.cnt_data_in   <= '0;
      bus.result        <= '0;
`ifndef CNT_ARB_FIXED_PRIORITY_EN
      last_gnt          <= 1'b1;
`endif
    end else begin
      bus.gnt0  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner           <= win;
            dir_q           <= sel_op[0];
            len_q           <= sel_len;
            bus.cnt_data_in <= sel_ldval;
            bus.busy        <= 1'b1;
`ifndef CNT_ARB_FIXED_PRIORITY_EN
            last_gnt        <= win;
`endif
            if (win) bus.gnt1 <= 1'b1;
            else     bus.gnt0 <= 1'b1;
            if (sel_op[1]) begin
              state          <= LOAD;
              bus.cnt_ld_cnt <= 1'b0;
            end else if (sel_len != '0) begin
              state             <= RUN;
              remaining         <= sel_len;
              bus.cnt_count_enb <= 1'b1;
              bus.cnt_updn_cnt  <= sel_op[0];
            end else begin
              state <= DONE;
              if (win) bus.done1 <= 1'b1;
              else     bus.done0 <= 1'b1;
            end
          end
        end
        LOAD: begin
          bus.cnt_ld_cnt <= 1'b1;
          if (len_q != '0) begin
            state             <= RUN;
            remaining         <= len_q;
            bus.cnt_count_enb <= 1'b1;
            bus.cnt_updn_cnt  <= dir_q;
          end else begin
            state <= DONE;
            if (owner) bus.done1 <= 1'b1;
            else       bus.done0 <= 1'b1;
          end
        end
        RUN: begin
          if (remaining == LEN_W'(1)) begin
            state             <= DONE;
            bus.cnt_count_enb <= 1'b0;
            if (owner) bus.done1 <= 1'b1;
            else       bus.done0 <= 1'b1;
          end else begin
            remaining <= remaining - LEN_W'(1);
          end
        end
        DONE: begin
          // Counter has settled after the last enabled edge; capture it here
          bus.result <= bus.cnt_data_out;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed cases plus randomized traffic against a
// transaction-level model; honours CNT_ARB_FIXED_PRIORITY_EN like the design.
module tb_counter_arbiter;
  localparam int BOUND = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] cnt_val = 16'h1234;
  int total = 0;
  int bad = 0;
  int w0 = 0;
  int w1 = 0;

  counter_arbiter_if bus ();

  counter_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Shared up/down counter with active-low load, never reset by the arbiter
  always @(posedge clk) begin
    if (!bus.cnt_ld_cnt)        cnt_val <= bus.cnt_data_in;
    else if (bus.cnt_count_enb) cnt_val <= bus.cnt_updn_cnt ? cnt_val + 16'd1 : cnt_val - 16'd1;
  end
  assign bus.cnt_data_out = cnt_val;

  // Transaction model: k is the cycle index within the current operation (0 = idle)
  int k = 0, n = 0, m_ld = 0, m_len = 0;
  bit m_own = 1'b0, m_up = 1'b0, m_last = 1'b1, model_ready = 1'b0;
  logic [15:0] m_din = '0, m_res = '0, m_final = '0, m_start;
  logic [1:0]  m_op;
  logic [15:0] m_ldv;
  logic [7:0]  m_l;

  always @(posedge clk) begin
    if (rst) begin
      k = 0; m_last = 1'b1; m_din = '0; m_res = '0; model_ready = 1'b1;
    end else if (k == 0) begin
      if (bus.req0 || bus.req1) begin
`ifdef CNT_ARB_FIXED_PRIORITY_EN
        m_own = !bus.req0;
`else
        m_own = (bus.req0 && bus.req1) ? !m_last : bus.req1;
`endif
        m_last  = m_own;
        m_op    = m_own ? bus.op1 : bus.op0;
        m_ldv   = m_own ? bus.ldval1 : bus.ldval0;
        m_l     = m_own ? bus.len1 : bus.len0;
        m_ld    = int'(m_op[1]);
        m_up    = m_op[0];
        m_len   = int'(m_l);
        m_din   = m_ldv;
        m_start = m_op[1] ? m_ldv : cnt_val;
        m_final = m_up ? 16'(m_start + 16'(m_l)) : 16'(m_start - 16'(m_l));
        n = m_ld + m_len + 1;
        k = 1;
      end
    end else if (k == n) begin
      m_res = m_final;
      k = 0;
    end else begin
      k = k + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next negedge, compare every output with the model, retire granted requests
  task automatic tick();
    bit enb;
    @(negedge clk);
    if (model_ready) begin
      enb = (k != 0) && (k > m_ld) && (k <= m_ld + m_len);
      chk("busy",   32'(bus.busy),  32'(k != 0));
      chk("gnt0",   32'(bus.gnt0),  32'(k == 1 && !m_own));
      chk("gnt1",   32'(bus.gnt1),  32'(k == 1 && m_own));
      chk("done0",  32'(bus.done0), 32'(k != 0 && k == n && !m_own));
      chk("done1",  32'(bus.done1), 32'(k != 0 && k == n && m_own));
      chk("ld_cnt", 32'(bus.cnt_ld_cnt), 32'(!(k == 1 && m_ld == 1)));
      chk("enb",    32'(bus.cnt_count_enb), 32'(enb));
      if (enb) chk("updn", 32'(bus.cnt_updn_cnt), 32'(m_up));
      chk("data_in", 32'(bus.cnt_data_in), 32'(m_din));
      chk("result",  32'(bus.result), 32'(m_res));
    end
    if (bus.req0) begin
      if (bus.gnt0) begin
        chk("wait0", 32'(w0 <= BOUND), 32'd1);
        bus.req0 = 1'b0; w0 = 0;
      end else if (++w0 > BOUND) begin
        chk("starve0", 32'(w0 <= BOUND), 32'd1);
        bus.req0 = 1'b0; w0 = 0;
      end
    end
    if (bus.req1) begin
      if (bus.gnt1) begin
        chk("wait1", 32'(w1 <= BOUND), 32'd1);
        bus.req1 = 1'b0; w1 = 0;
      end else if (++w1 > BOUND) begin
        chk("starve1", 32'(w1 <= BOUND), 32'd1);
        bus.req1 = 1'b0; w1 = 0;
      end
    end
  endtask

  task automatic ticks(input int c);
    for (int i = 0; i < c; i++) tick();
  endtask

  task automatic set_req(input int who, input logic [1:0] op, input logic [15:0] ld, input logic [7:0] len);
    if (who == 0) begin
      bus.op0 = op; bus.ldval0 = ld; bus.len0 = len; bus.req0 = 1'b1; w0 = 0;
    end else begin
      bus.op1 = op; bus.ldval1 = ld; bus.len1 = len; bus.req1 = 1'b1; w1 = 0;
    end
  endtask

  task automatic drain();
    int c = 0;
    while ((bus.req0 || bus.req1 || bus.busy) && c < 400) begin tick(); c++; end
    chk("drain", 32'(c < 400), 32'd1);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; ticks(2); rst = 1'b0; tick();
  endtask

  initial begin
    bit got, g1, saw_done;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = '0; bus.op1 = '0; bus.ldval0 = '0; bus.ldval1 = '0; bus.len0 = '0; bus.len1 = '0;

    // Reset values
    do_reset();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ld", 32'(bus.cnt_ld_cnt), 32'd1);
    chk("rst_enb", 32'(bus.cnt_count_enb), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_gd", 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1}), 32'd0);

    // Load 0x0010, count up 5
    set_req(0, 2'b11, 16'h0010, 8'd5);
    tick();
    chk("up_gnt0", 32'(bus.gnt0), 32'd1);
    chk("up_load", 32'(bus.cnt_ld_cnt), 32'd0);
    ticks(5);
    chk("up_done_early", 32'(bus.done0), 32'd0);
    tick();
    chk("up_done0_c7", 32'(bus.done0), 32'd1);
    tick();
    chk("up_result", 32'(bus.result), 32'h0015);
    ticks(2);

    // Load 0, count down 1: wraps to 0xFFFF
    set_req(1, 2'b10, 16'h0000, 8'd1);
    tick();
    chk("dn_gnt1", 32'(bus.gnt1), 32'd1);
    ticks(2);
    chk("dn_done1", 32'(bus.done1), 32'd1);
    tick();
    chk("dn_result", 32'(bus.result), 32'hFFFF);
    ticks(2);

    // No load, len 0: grant and completion together, counter untouched
    set_req(0, 2'b00, 16'hABCD, 8'd0);
    tick();
    chk("z_gnt0", 32'(bus.gnt0), 32'd1);
    chk("z_done0", 32'(bus.done0), 32'd1);
    chk("z_ld", 32'(bus.cnt_ld_cnt), 32'd1);
    chk("z_enb", 32'(bus.cnt_count_enb), 32'd0);
    tick();
    chk("z_result", 32'(bus.result), 32'hFFFF);
    ticks(2);

    // Simultaneous requests, twice back-to-back
    do_reset();
    set_req(0, 2'b11, 16'h0100, 8'd2);
    set_req(1, 2'b01, 16'h0200, 8'd3);
    tick();
    chk("arb1_gnt0", 32'(bus.gnt0), 32'd1);
    chk("arb1_gnt1", 32'(bus.gnt1), 32'd0);
    set_req(0, 2'b11, 16'h0100, 8'd2);
    got = 1'b0; g1 = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      tick();
      if (bus.gnt0 || bus.gnt1) begin got = 1'b1; g1 = bus.gnt1; end
    end
    chk("arb2_seen", 32'(got), 32'd1);
`ifdef CNT_ARB_FIXED_PRIORITY_EN
    chk("arb2_winner", 32'(g1), 32'd0);
`else
    chk("arb2_winner", 32'(g1), 32'd1);
`endif
    drain();

    // Reset in the third RUN cycle of a len 10 op aborts without completion
    set_req(0, 2'b01, 16'h0000, 8'd10);
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_enb", 32'(bus.cnt_count_enb), 32'd0);
    chk("ab_done0", 32'(bus.done0), 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.done0) saw_done = 1'b1;
    end
    chk("ab_no_done", 32'(saw_done), 32'd0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      for (int r = 0; r < 2; r++) begin
        if (((r == 0) ? !bus.req0 : !bus.req1) && $urandom_range(0, 3) == 0)
          set_req(r, 2'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 4)));
      end
    end
    rst = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
